bcd_counter4: RTL and testbench
===============================

BCD_COUNTER4 -- requirements
Module: bcd_counter4

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 100000000, meaning clk cycles per count step (1 Hz at 100 MHz); legal range >= 2.
REQ-002 The block SHALL have parameter BLANK_LZ, default 1; 1 enables leading-zero blanking on LEs.
REQ-003 The block SHALL have parameter POINT_MASK, default 4'b0000, which is driven constant on points.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-low.
REQ-006 en  input  1  count enable; 0 freezes the prescaler and the count.
REQ-007 up  input  1  direction; 1 counts up, 0 counts down.
REQ-008 clr  input  1  synchronous clear to 0000.
REQ-009 load  input  1  synchronous load of load_val.
REQ-010 load_val  input  16  four BCD digits, [15:12] most significant.
REQ-011 hexs  output  16  four BCD digits of the current count; feeds the display driver hexs input.
REQ-012 points  output  4  decimal-point enables; feeds the display driver points input.
REQ-013 LEs  output  4  per-digit blank, 1 = digit blanked; feeds the display driver LEs input.
REQ-014 wrap  output  1  one-cycle pulse on 9999->0000 (up) or 0000->9999 (down).

Function
REQ-015 The prescaler SHALL count 0..TICK_DIV-1 while en=1 and hold while en=0.
REQ-016 tick SHALL assert for one cycle when the prescaler equals TICK_DIV-1 and en=1; the prescaler returns to 0 on that cycle.
REQ-017 On tick with up=1, the count SHALL increment in BCD: a digit at 9 goes to 0 and carries into the next digit.
REQ-018 On tick with up=0, the count SHALL decrement in BCD: a digit at 0 goes to 9 and borrows from the next digit.
REQ-019 The count SHALL wrap 9999->0000 (up) and 0000->9999 (down), and wrap SHALL be 1 in exactly the cycle the wrapped value appears on hexs.
REQ-020 Update latency: hexs SHALL show the new value on the clk edge that samples tick, i.e. one cycle after the prescaler reaches TICK_DIV-1.
REQ-021 Priority SHALL be clr > load > tick; clr or load also resets the prescaler to 0, and a suppressed tick does not count and does not pulse wrap.
REQ-022 On load, each load_val digit greater than 9 SHALL be stored as 9; legal digits are stored unchanged.
REQ-023 clr and load SHALL act regardless of en.
REQ-024 up MAY change on any cycle; the value sampled on the tick cycle governs that step.
REQ-025 The count register SHALL never hold a digit value greater than 9.
REQ-026 With BLANK_LZ=1, LEs[i] for i=3..1 SHALL be 1 when digit i and all higher digits are 0; LEs[0] SHALL always be 0.
REQ-027 With BLANK_LZ=0, LEs SHALL be 4'b0000.
REQ-028 LEs SHALL be derived from the registered count with zero additional latency (same cycle as hexs).
REQ-029 points SHALL equal POINT_MASK at all times after reset.

Reset
REQ-030 While rst=0, hexs SHALL be 16'h0000, the prescaler 0 and wrap 0; LEs SHALL be 4'b1110 (BLANK_LZ=1) or 4'b0000 (BLANK_LZ=0); points SHALL be POINT_MASK.
REQ-031 Assertion of rst mid-count SHALL clear all state immediately, without waiting for a clk edge.
REQ-032 After rst deasserts, the first tick SHALL occur TICK_DIV enabled cycles later.

Verification (TICK_DIV=4, BLANK_LZ=1)
REQ-033 Reset, then en=1, up=1 for 40 cycles -> hexs steps 0000, 0001 ... 0010, advancing every 4th cycle; LEs goes 1110 -> 1100 at 0010.
REQ-034 load_val=16'h9998 with load=1 for one cycle, then up=1, en=1 -> hexs 9998, 9999, then 0000 with wrap=1 for exactly one cycle; LEs=1110 at 0000.
REQ-035 load_val=16'h0001 loaded, then up=0 -> hexs 0001, 0000, then 9999 with a wrap pulse; LEs 1110 -> 1110 -> 0000.
REQ-036 load_val=16'hA3F0 loaded -> hexs=9390; load and clr asserted together -> hexs=0000 and the prescaler restarts.
REQ-037 en=0 for 10 cycles mid-count -> hexs and the prescaler are frozen; resuming en=1 completes the remaining prescaler count before the next step.
REQ-038 Drive rst=0 asynchronously between clk edges at count 0123 -> hexs=0000 and wrap=0 immediately; no step occurs until 4 enabled cycles after release.

Source files
------------

// File: rtl/bcd_counter4.sv
// Four-digit BCD up/down counter with prescaler, clear/load, wrap pulse and
// display-driver side outputs (digit blanking and decimal points).
module bcd_counter4 #(
  parameter int unsigned TICK_DIV   = 100000000,
  parameter bit          BLANK_LZ   = 1'b1,
  parameter logic [3:0]  POINT_MASK = 4'b0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        up,
  input  logic        clr,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] hexs,
  output logic [3:0]  points,
  output logic [3:0]  LEs,
  output logic        wrap
);

  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc;
  logic          tick;
  logic [15:0]   step_val;
  logic          step_wrap;
  logic [15:0]   load_sat;
  logic [3:0]    digit;
  logic          carry;

  assign tick = en && (presc == PRE_MAX);

  // Ripple carry/borrow through the digits; a carry out of the top digit is a wrap.
  always_comb begin
    step_val = hexs;
    carry    = 1'b1;
    digit    = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      digit = hexs[4*i +: 4];
      if (carry) begin
        if (up) begin
          if (digit == 4'd9) begin
            step_val[4*i +: 4] = 4'd0;
          end else begin
            step_val[4*i +: 4] = digit + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (digit == 4'd0) begin
            step_val[4*i +: 4] = 4'd9;
          end else begin
            step_val[4*i +: 4] = digit - 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
    step_wrap = carry;
  end

  // Illegal load digits saturate to 9 so the count register stays valid BCD.
  always_comb begin
    load_sat = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      load_sat[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hexs  <= '0;
      presc <= '0;
      wrap  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (clr) begin
        hexs  <= '0;
        presc <= '0;
      end else if (load) begin
        hexs  <= load_sat;
        presc <= '0;
      end else if (tick) begin
        hexs  <= step_val;
        presc <= '0;
        wrap  <= step_wrap;
      end else if (en) begin
        presc <= presc + 1'b1;
      end
    end
  end

  always_comb begin
    LEs = '0;
    if (BLANK_LZ) begin
      LEs[3] = (hexs[15:12] == 4'd0);
      LEs[2] = LEs[3] && (hexs[11:8] == 4'd0);
      LEs[1] = LEs[2] && (hexs[7:4] == 4'd0);
    end
  end

  assign points = POINT_MASK;

endmodule

// File: tb/tb_bcd_counter4.sv
// Directed self-checking bench for bcd_counter4 with a 4-cycle prescaler.
module tb_bcd_counter4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        up;
  logic        clr;
  logic        load;
  logic [15:0] load_val;
  logic [15:0] hexs;
  logic [3:0]  points;
  logic [3:0]  LEs;
  logic        wrap;

  int n_chk  = 0;
  int n_fail = 0;

  bcd_counter4 #(
    .TICK_DIV  (4),
    .BLANK_LZ  (1'b1),
    .POINT_MASK(4'b0101)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .up      (up),
    .clr     (clr),
    .load    (load),
    .load_val(load_val),
    .hexs    (hexs),
    .points  (points),
    .LEs     (LEs),
    .wrap    (wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_state(input string tag, input logic [15:0] h, input logic [3:0] le,
                           input logic w);
    chk({tag, ".hexs"}, hexs, h);
    chk({tag, ".LEs"}, {12'h000, LEs}, {12'h000, le});
    chk({tag, ".wrap"}, {15'h0000, wrap}, {15'h0000, w});
  endtask

  initial begin
    int v;
    logic [15:0] exp_h;
    logic [3:0]  exp_le;

    rst = 1'b0; en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0; load_val = '0;
    cyc(3);
    chk_state("reset", 16'h0000, 4'b1110, 1'b0);
    chk("reset.points", {12'h000, points}, 16'h0005);

    // Count up from reset: one step every fourth enabled cycle.
    rst = 1'b1; en = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      cyc(1);
      v = k / 4;
      exp_h  = {8'h00, 4'(v / 10), 4'(v % 10)};
      exp_le = (v >= 10) ? 4'b1100 : 4'b1110;
      chk_state($sformatf("up%0d", k), exp_h, exp_le, 1'b0);
    end
    chk("run.points", {12'h000, points}, 16'h0005);

    // Up wrap 9999 -> 0000.
    load_val = 16'h9998; load = 1'b1;
    cyc(1); load = 1'b0;
    chk_state("ld9998", 16'h9998, 4'b0000, 1'b0);
    cyc(3); chk_state("hold9998", 16'h9998, 4'b0000, 1'b0);
    cyc(1); chk_state("to9999", 16'h9999, 4'b0000, 1'b0);
    cyc(3); chk_state("hold9999", 16'h9999, 4'b0000, 1'b0);
    cyc(1); chk_state("upwrap", 16'h0000, 4'b1110, 1'b1);
    cyc(1); chk_state("upwrap_end", 16'h0000, 4'b1110, 1'b0);

    // Down wrap 0000 -> 9999.
    load_val = 16'h0001; load = 1'b1; up = 1'b0;
    cyc(1); load = 1'b0;
    chk_state("ld0001", 16'h0001, 4'b1110, 1'b0);
    cyc(4); chk_state("dn0000", 16'h0000, 4'b1110, 1'b0);
    cyc(4); chk_state("dnwrap", 16'h9999, 4'b0000, 1'b1);
    cyc(1); chk_state("dnwrap_end", 16'h9999, 4'b0000, 1'b0);

    // Saturating load, then clr beats load and restarts the prescaler.
    load_val = 16'hA3F0; load = 1'b1;
    cyc(1); load = 1'b0;
    chk_state("sat", 16'h9390, 4'b0000, 1'b0);
    cyc(2);
    clr = 1'b1; load = 1'b1; load_val = 16'h1234; up = 1'b1;
    cyc(1); clr = 1'b0; load = 1'b0;
    chk_state("clr_ld", 16'h0000, 4'b1110, 1'b0);
    cyc(3); chk_state("clr_pre", 16'h0000, 4'b1110, 1'b0);
    cyc(1); chk_state("clr_step", 16'h0001, 4'b1110, 1'b0);

    // Load on a tick cycle suppresses the step.
    cyc(3);
    load_val = 16'h5555; load = 1'b1;
    cyc(1); load = 1'b0;
    chk_state("ld_tick", 16'h5555, 4'b0000, 1'b0);

    // Freeze with en=0, then finish the remaining prescaler count.
    cyc(2); en = 1'b0;
    cyc(10); chk_state("frozen", 16'h5555, 4'b0000, 1'b0);
    en = 1'b1;
    cyc(1); chk_state("resume1", 16'h5555, 4'b0000, 1'b0);
    cyc(1); chk_state("resume2", 16'h5556, 4'b0000, 1'b0);

    // clr acts with en=0.
    en = 1'b0; clr = 1'b1;
    cyc(1); clr = 1'b0; en = 1'b1;
    chk_state("clr_noen", 16'h0000, 4'b1110, 1'b0);

    // Multi-digit carry and borrow.
    load_val = 16'h0999; load = 1'b1;
    cyc(1); load = 1'b0;
    chk_state("ld0999", 16'h0999, 4'b1000, 1'b0);
    cyc(4); chk_state("carry", 16'h1000, 4'b0000, 1'b0);
    up = 1'b0;
    cyc(4); chk_state("borrow", 16'h0999, 4'b1000, 1'b0);

    // Asynchronous reset between edges at 0123.
    up = 1'b1; load_val = 16'h0123; load = 1'b1;
    cyc(1); load = 1'b0;
    chk_state("ld0123", 16'h0123, 4'b1000, 1'b0);
    cyc(2);
    #2 rst = 1'b0;
    #1 chk_state("async_rst", 16'h0000, 4'b1110, 1'b0);
    @(negedge clk);
    chk_state("in_rst", 16'h0000, 4'b1110, 1'b0);
    rst = 1'b1;
    cyc(3); chk_state("post_rst3", 16'h0000, 4'b1110, 1'b0);
    cyc(1); chk_state("post_rst4", 16'h0001, 4'b1110, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
